and_gate_arbiter: RTL

Round-robin arbiter and sequencer that shares a single parameterized bitwise-AND datapath (one `and_gate` instance) among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the AND result with the winner's index, and holds it in a single-entry output buffer until the consumer accepts it. It sits between several independent logic-op clients and one shared logic unit.

---
 rtl/and_gate_arbiter_pkg.sv | 14 +
 rtl/and_gate_arbiter_and_gate.sv | 12 +
 rtl/and_gate_arbiter_rr_arbiter.sv | 35 +++
 rtl/and_gate_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/and_gate_arbiter_pkg.sv
// Shared types and helpers for the round-robin AND-datapath arbiter.
package and_gate_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned idw_f(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/and_gate_arbiter_and_gate.sv
// Parameterized bitwise AND, the single shared logic unit.
module and_gate #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    assign Y = A & B;

endmodule

// File: rtl/and_gate_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from LAST+1 upward, modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] REQ_VALID,
    input  logic [IDW-1:0]  LAST,
    input  logic            CAN_GRANT,
    output logic [NREQ-1:0] GRANT,
    output logic [IDW-1:0]  WIN_ID
);

    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] idx_l;
        logic found;
        GRANT  = '0;
        WIN_ID = '0;
        found  = 1'b0;
        idx    = 0;
        idx_l  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx   = (32'(LAST) + i) % NREQ;
            idx_l = IDW'(idx);
            if (!found && REQ_VALID[idx_l]) begin
                found  = 1'b1;
                WIN_ID = idx_l;
            end
        end
        if (found && CAN_GRANT) begin
            GRANT[WIN_ID] = 1'b1;
        end
    end

endmodule

// File: rtl/and_gate_arbiter.sv
// Round-robin sharing of one AND datapath among NREQ requesters,
// with a single-entry registered result buffer.
module and_gate_arbiter
    import and_gate_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = idw_f(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ*WIDTH-1:0] REQ_A,
    input  logic [NREQ*WIDTH-1:0] REQ_B,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [WIDTH-1:0]      RSP_DATA,
    output logic [IDW-1:0]        RSP_ID,
    output logic                  BUSY
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;

    logic             can_grant;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] op_a, op_b, and_y;
    logic             transfer;

    assign can_grant = (state_q == ST_EMPTY) || RSP_READY;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .REQ_VALID (REQ_VALID),
        .LAST      (last_q),
        .CAN_GRANT (can_grant),
        .GRANT     (grant),
        .WIN_ID    (win_id)
    );

    // Operands only feed the result register, never an output directly.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                op_a = REQ_A[i*WIDTH +: WIDTH];
                op_b = REQ_B[i*WIDTH +: WIDTH];
            end
        end
    end

    and_gate #(
        .WIDTH (WIDTH)
    ) u_and_gate (
        .A (op_a),
        .B (op_b),
        .Y (and_y)
    );

    assign transfer = |grant;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (transfer) begin
            state_d = ST_FULL;
            data_d  = and_y;
            id_d    = win_id;
            last_d  = win_id;
        end else if (state_q == ST_FULL && RSP_READY) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign REQ_READY = grant;
    assign RSP_VALID = (state_q == ST_FULL);
    assign RSP_DATA  = data_q;
    assign RSP_ID    = id_q;
    assign BUSY      = RSP_VALID;

endmodule
